// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one main-memory port between I-cache refills
// and D-cache refills or write-through stores, with a pipeline stall.
module mem_arbiter #(
   parameter  int W           = 32,
   parameter  int BLOCK_WORDS = 4,
   localparam int IW          = $clog2(BLOCK_WORDS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ic_req,
   input  logic [W-1:0]  ic_addr,
   output logic          ic_gnt,
   output logic          ic_rvalid,
   output logic [W-1:0]  ic_rdata,
   output logic [IW-1:0] ic_widx,
   output logic          ic_done,
   input  logic          dc_req,
   input  logic          dc_we,
   input  logic [W-1:0]  dc_addr,
   input  logic [W-1:0]  dc_wdata,
   output logic          dc_gnt,
   output logic          dc_rvalid,
   output logic [W-1:0]  dc_rdata,
   output logic [IW-1:0] dc_widx,
   output logic          dc_done,
   output logic          mem_req,
   output logic          mem_we,
   output logic [W-1:0]  mem_addr,
   output logic [W-1:0]  mem_wdata,
   input  logic          mem_ack,
   input  logic [W-1:0]  mem_rdata,
   output logic          stall
);

   typedef enum logic [2:0] {IDLE, IC_RD, DC_RD, DC_WR, DONE} state_t;

   state_t          r_state;
   logic [IW-1:0]   r_cnt;
   logic            r_last_dc;
   logic [W-1:2]    r_addr;
   logic [W-1:0]    r_wdata;
   logic            r_ic_gnt, r_ic_rvalid, r_ic_done;
   logic            r_dc_gnt, r_dc_rvalid, r_dc_done;
   logic [W-1:0]    r_ic_rdata, r_dc_rdata;
   logic [IW-1:0]   r_ic_widx, r_dc_widx;
   logic            w_pick_dc;
   logic            w_last_word;
   logic            w_unused;

   // DC wins a tie unless it was the most recent grant.
   assign w_pick_dc   = dc_req & (~ic_req | ~r_last_dc);
   assign w_last_word = (r_cnt == IW'(BLOCK_WORDS - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_last_dc   <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_ic_gnt    <= 1'b0;
         r_ic_rvalid <= 1'b0;
         r_ic_done   <= 1'b0;
         r_ic_rdata  <= '0;
         r_ic_widx   <= '0;
         r_dc_gnt    <= 1'b0;
         r_dc_rvalid <= 1'b0;
         r_dc_done   <= 1'b0;
         r_dc_rdata  <= '0;
         r_dc_widx   <= '0;
      end else begin
         r_ic_gnt    <= 1'b0;
         r_ic_rvalid <= 1'b0;
         r_ic_done   <= 1'b0;
         r_dc_gnt    <= 1'b0;
         r_dc_rvalid <= 1'b0;
         r_dc_done   <= 1'b0;
         case (r_state)
            IDLE: if (ic_req | dc_req) begin
               r_cnt <= '0;
               if (w_pick_dc) begin
                  r_last_dc <= 1'b1;
                  r_dc_gnt  <= 1'b1;
                  r_addr    <= dc_addr[W-1:2];
                  r_wdata   <= dc_wdata;
                  r_state   <= dc_we ? DC_WR : DC_RD;
               end else begin
                  r_last_dc <= 1'b0;
                  r_ic_gnt  <= 1'b1;
                  r_addr    <= ic_addr[W-1:2];
                  r_state   <= IC_RD;
               end
            end
            IC_RD, DC_RD: if (mem_ack) begin
               if (r_state == IC_RD) begin
                  r_ic_rvalid <= 1'b1;
                  r_ic_rdata  <= mem_rdata;
                  r_ic_widx   <= r_cnt;
               end else begin
                  r_dc_rvalid <= 1'b1;
                  r_dc_rdata  <= mem_rdata;
                  r_dc_widx   <= r_cnt;
               end
               r_cnt <= w_last_word ? r_cnt : r_cnt + 1'b1;
               if (w_last_word) begin
                  r_state   <= DONE;
                  r_ic_done <= (r_state == IC_RD);
                  r_dc_done <= (r_state == DC_RD);
               end
            end
            DC_WR: if (mem_ack) begin
               r_state   <= DONE;
               r_dc_done <= 1'b1;
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   // Memory port is a pure decode of the latched transaction and word counter.
   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (r_state)
         IC_RD, DC_RD: begin
            mem_req  = 1'b1;
            mem_addr = {r_addr[W-1:IW+2], r_cnt, 2'b00};
         end
         DC_WR: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {r_addr, 2'b00};
            mem_wdata = r_wdata;
         end
         default: ;
      endcase
   end

   assign ic_gnt    = r_ic_gnt;
   assign ic_rvalid = r_ic_rvalid;
   assign ic_rdata  = r_ic_rdata;
   assign ic_widx   = r_ic_widx;
   assign ic_done   = r_ic_done;
   assign dc_gnt    = r_dc_gnt;
   assign dc_rvalid = r_dc_rvalid;
   assign dc_rdata  = r_dc_rdata;
   assign dc_widx   = r_dc_widx;
   assign dc_done   = r_dc_done;

   assign stall = (ic_req & ~ic_done) | (dc_req & ~dc_done);

   assign w_unused = ^{ic_addr[1:0], dc_addr[1:0], r_addr[IW+1:2]};

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic, all checked
// against a transaction-level model of the arbitration and burst rules.
module tb_mem_arbiter;
   localparam int W  = 32;
   localparam int BW = 4;
   localparam int IW = $clog2(BW);

   logic          clk = 1'b0;
   logic          rst;
   logic          ic_req, dc_req, dc_we, mem_ack;
   logic [W-1:0]  ic_addr, dc_addr, dc_wdata, mem_rdata;
   logic          ic_gnt, ic_rvalid, ic_done, dc_gnt, dc_rvalid, dc_done;
   logic [W-1:0]  ic_rdata, dc_rdata, mem_addr, mem_wdata;
   logic [IW-1:0] ic_widx, dc_widx;
   logic          mem_req, mem_we, stall;

   always #5 clk = ~clk;

   mem_arbiter #(.W(W), .BLOCK_WORDS(BW)) dut (
      .clk(clk), .rst(rst),
      .ic_req(ic_req), .ic_addr(ic_addr), .ic_gnt(ic_gnt), .ic_rvalid(ic_rvalid),
      .ic_rdata(ic_rdata), .ic_widx(ic_widx), .ic_done(ic_done),
      .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
      .dc_gnt(dc_gnt), .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata), .dc_widx(dc_widx),
      .dc_done(dc_done),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Model: the owner of the memory port, how many words it still needs, and
   // whether we are in the one-cycle completion or the idle bubble.
   typedef enum {P_IDLE, P_BUSY, P_DONE} ph_t;
   ph_t         ph      = P_IDLE;
   bit          last_dc = 1'b0;
   bit          m_dc, m_we;
   logic [31:0] m_addr, m_wdata;
   int          acked, need;
   bit          auto_req = 1'b0;
   int          ic_wait = 0, dc_wait = 0;
   int          ic_rv_n = 0, dc_rv_n = 0;
   logic [31:0] adr_q[$];
   bit          gnt_q[$];

   task automatic step();
      bit          e_ig, e_dg, e_irv, e_drv, e_id, e_dd;
      logic [31:0] e_data, e_ma;
      int          e_idx;
      e_ig = 0; e_dg = 0; e_irv = 0; e_drv = 0; e_id = 0; e_dd = 0;
      e_data = '0; e_idx = 0;
      @(negedge clk);
      if (rst) begin
         ph = P_IDLE;
         last_dc = 1'b0;
      end else begin
         case (ph)
            P_IDLE: if (ic_req || dc_req) begin
               m_dc    = dc_req && (!ic_req || !last_dc);
               last_dc = m_dc;
               m_we    = m_dc && dc_we;
               m_addr  = m_dc ? dc_addr : ic_addr;
               m_wdata = dc_wdata;
               acked   = 0;
               need    = m_we ? 1 : BW;
               ph      = P_BUSY;
               if (m_dc) e_dg = 1; else e_ig = 1;
            end
            P_BUSY: if (mem_ack) begin
               if (!m_we) begin
                  e_data = mem_rdata;
                  e_idx  = acked;
                  if (m_dc) e_drv = 1; else e_irv = 1;
               end
               acked++;
               if (acked == need) begin
                  ph = P_DONE;
                  if (m_dc) e_dd = 1; else e_id = 1;
               end
            end
            P_DONE: ph = P_IDLE;
         endcase
      end

      chk("ic_gnt", ic_gnt, e_ig);
      chk("dc_gnt", dc_gnt, e_dg);
      chk("ic_rvalid", ic_rvalid, e_irv);
      chk("dc_rvalid", dc_rvalid, e_drv);
      chk("ic_done", ic_done, e_id);
      chk("dc_done", dc_done, e_dd);
      chk("mem_req", mem_req, ph == P_BUSY);
      if (ph == P_BUSY) begin
         e_ma = m_we ? (m_addr & ~32'h3) : (m_addr & ~32'(BW * 4 - 1)) + 32'(4 * acked);
         chk("mem_addr", mem_addr, e_ma);
         chk("mem_we", mem_we, m_we);
         if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
         adr_q.push_back(mem_addr);
      end
      if (e_irv) begin
         chk("ic_rdata", ic_rdata, e_data);
         chk("ic_widx", 32'(ic_widx), 32'(e_idx));
      end
      if (e_drv) begin
         chk("dc_rdata", dc_rdata, e_data);
         chk("dc_widx", 32'(dc_widx), 32'(e_idx));
      end
      chk("stall", stall, (ic_req & ~e_id) | (dc_req & ~e_dd));
      if (dc_gnt) gnt_q.push_back(1'b1);
      if (ic_gnt) gnt_q.push_back(1'b0);
      if (ic_rvalid) ic_rv_n++;
      if (dc_rvalid) dc_rv_n++;

      // Requesters release on completion; memory supplies fresh data each cycle.
      if (e_id) ic_req = 1'b0;
      if (e_dd) dc_req = 1'b0;
      mem_rdata = $urandom;
      if (auto_req) begin
         if (!ic_req) begin
            if (ic_wait > 0) ic_wait--;
            else begin
               ic_req  = 1'b1;
               ic_addr = $urandom;
               ic_wait = $urandom_range(0, 6);
            end
         end
         if (!dc_req) begin
            if (dc_wait > 0) dc_wait--;
            else begin
               dc_req   = 1'b1;
               dc_we    = 1'($urandom_range(0, 1));
               dc_addr  = $urandom;
               dc_wdata = $urandom;
               dc_wait  = $urandom_range(0, 6);
            end
         end
         mem_ack = 1'($urandom_range(0, 1));
      end
   endtask

   initial begin
      rst = 1'b1; ic_req = 0; dc_req = 0; dc_we = 0; mem_ack = 0;
      ic_addr = '0; dc_addr = '0; dc_wdata = '0; mem_rdata = '0;
      repeat (2) step();
      chk("rst_ctrl", {ic_gnt, ic_rvalid, ic_done, dc_gnt, dc_rvalid, dc_done,
                       mem_req, mem_we, stall, ic_widx, dc_widx}, '0);
      chk("rst_mem_addr", mem_addr, '0);
      chk("rst_mem_wdata", mem_wdata, '0);
      chk("rst_rdata", ic_rdata | dc_rdata, '0);
      rst = 1'b0;
      step();

      // IC refill, zero-wait memory
      adr_q.delete();
      ic_addr = 32'h1000_0014; ic_req = 1; mem_ack = 1;
      repeat (7) step();
      chk("t1_naddr", adr_q.size(), 4);
      for (int i = 0; i < 4; i++) chk("t1_addr", adr_q[i], 32'h1000_0010 + 32'(4 * i));

      // simultaneous requests: DC, IC, then DC on the next tie
      gnt_q.delete();
      dc_we = 0; dc_addr = 32'h2000_0040; ic_addr = 32'h3000_0000;
      ic_req = 1; dc_req = 1;
      repeat (12) step();
      ic_req = 1; dc_req = 1;
      repeat (12) step();
      chk("t2_ngnt", gnt_q.size(), 4);
      for (int i = 0; i < 4; i++) chk("t2_order", gnt_q[i], (i % 2 == 0));

      // store with three wait states
      adr_q.delete();
      mem_ack = 0; dc_we = 1; dc_addr = 32'h0000_0103; dc_wdata = 32'hDEAD_BEEF; dc_req = 1;
      dc_rv_n = 0;
      repeat (4) step();
      mem_ack = 1;
      step();
      mem_ack = 0;
      repeat (2) step();
      chk("t3_naddr", adr_q.size(), 4);
      for (int i = 0; i < 4; i++) chk("t3_addr", adr_q[i], 32'h0000_0100);
      chk("t3_rvalid", dc_rv_n, 0);

      // read with acks on alternate cycles
      dc_rv_n = 0; dc_we = 0; dc_addr = 32'h4000_0008; dc_req = 1; mem_ack = 0;
      for (int i = 0; i < 14; i++) begin
         step();
         mem_ack = ~mem_ack;
      end
      mem_ack = 0;
      repeat (2) step();
      chk("t4_rvalid", dc_rv_n, 4);

      // reset in the middle of an IC burst, then restart
      ic_addr = 32'h5000_0000; ic_req = 1; mem_ack = 1;
      repeat (3) step();
      rst = 1; ic_req = 0;
      step();
      chk("t5_mem_req", mem_req, 0);
      chk("t5_done", ic_done, 0);
      rst = 0;
      step();
      adr_q.delete();
      ic_req = 1;
      repeat (7) step();
      chk("t5_naddr", adr_q.size(), 4);
      chk("t5_word0", adr_q[0], 32'h5000_0000);

      // spurious acks with nothing outstanding
      mem_ack = 1;
      repeat (4) step();
      mem_ack = 0;

      auto_req = 1;
      repeat (3000) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
